// File: rtl/debounce_arb_pkg.sv
// Shared types and constants for the time-shared debounce arbiter.
package debounce_arb_pkg;

    typedef enum logic [1:0] {
        ST_ARB_IDLE,
        ST_ARB_COUNT,
        ST_ARB_COMMIT
    } estado_arb_t;

    localparam int unsigned ARB_CONTA_1S = 50000000;

endpackage

// File: rtl/debounce_rr_picker.sv
// Combinational round-robin picker: first set req bit above last_grant, wrapping.
module debounce_rr_picker #(
    parameter int unsigned N_INPUTS = 4
) (
    input  logic [N_INPUTS-1:0]         req,
    input  logic [$clog2(N_INPUTS)-1:0] last_grant,
    output logic                        valid,
    output logic [$clog2(N_INPUTS)-1:0] index
);

    localparam int unsigned GW = $clog2(N_INPUTS);

    int unsigned     pos;
    logic [GW-1:0]   cand;

    // Scanning from the farthest offset down lets the nearest hit win last.
    always_comb begin
        valid = 1'b0;
        index = '0;
        pos   = 0;
        cand  = '0;
        for (int unsigned k = N_INPUTS; k >= 1; k--) begin
            pos  = (32'(last_grant) + k) % N_INPUTS;
            cand = GW'(pos);
            if (req[cand]) begin
                valid = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/registrador.sv
// Generic enabled register with asynchronous active-high reset to zero.
module registrador #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_o <= '0;
        end else if (enable_i) begin
            data_o <= data_i;
        end
    end

endmodule

// File: rtl/debounce_arbiter.sv
// Time-shared debouncer: one delay counter granted round-robin across N_INPUTS lines.
// Optional two-flop input synchronizer enabled by defining DEBOUNCE_ARB_SYNC_EN.
module debounce_arbiter
    import debounce_arb_pkg::*;
#(
    parameter int unsigned N_INPUTS      = 4,
    parameter int unsigned TIME_DEBOUNCE = ARB_CONTA_1S,
    parameter int unsigned CNT_WIDTH     = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [N_INPUTS-1:0]         signal_i,
    output logic [N_INPUTS-1:0]         signal_o,
    output logic [N_INPUTS-1:0]         edge_o,
    output logic                        busy_o,
    output logic [$clog2(N_INPUTS)-1:0] grant_o
);

    localparam int unsigned          GW       = $clog2(N_INPUTS);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIME_DEBOUNCE - 1);

    logic [N_INPUTS-1:0]  in_s;
    logic [N_INPUTS-1:0]  req;
    logic [GW-1:0]        last_grant;
    logic                 sample;
    logic                 bounce;
    logic                 pick_valid;
    logic [GW-1:0]        pick_index;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    estado_arb_t          state;

`ifdef DEBOUNCE_ARB_SYNC_EN
    logic [N_INPUTS-1:0] sync_meta;
    logic [N_INPUTS-1:0] sync_out;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_meta <= '0;
            sync_out  <= '0;
        end else begin
            sync_meta <= signal_i;
            sync_out  <= sync_meta;
        end
    end

    assign in_s = sync_out;
`else
    assign in_s = signal_i;
`endif

    assign req    = in_s ^ signal_o;
    assign bounce = in_s[grant_o] != sample;

    debounce_rr_picker #(
        .N_INPUTS (N_INPUTS)
    ) u_picker (
        .req        (req),
        .last_grant (last_grant),
        .valid      (pick_valid),
        .index      (pick_index)
    );

    // Counter holds at its last value on the COUNT->COMMIT step; COMMIT clears it.
    always_comb begin
        cnt_d = '0;
        if (state == ST_ARB_COUNT && !bounce) begin
            cnt_d = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + 1'b1;
        end
    end

    registrador #(
        .DATA_WIDTH (CNT_WIDTH)
    ) u_cnt (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .enable_i (1'b1),
        .data_i   (cnt_d),
        .data_o   (cnt_q)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= ST_ARB_IDLE;
            signal_o   <= '0;
            edge_o     <= '0;
            busy_o     <= 1'b0;
            grant_o    <= '0;
            last_grant <= GW'(N_INPUTS - 1);
            sample     <= 1'b0;
        end else begin
            edge_o <= '0;
            case (state)
                ST_ARB_IDLE: begin
                    if (pick_valid) begin
                        grant_o    <= pick_index;
                        last_grant <= pick_index;
                        sample     <= in_s[pick_index];
                        busy_o     <= 1'b1;
                        state      <= ST_ARB_COUNT;
                    end
                end
                ST_ARB_COUNT: begin
                    if (bounce) begin
                        busy_o <= 1'b0;
                        state  <= ST_ARB_IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        state <= ST_ARB_COMMIT;
                    end
                end
                ST_ARB_COMMIT: begin
                    signal_o[grant_o] <= sample;
                    edge_o[grant_o]   <= 1'b1;
                    busy_o            <= 1'b0;
                    state             <= ST_ARB_IDLE;
                end
                default: begin
                    busy_o <= 1'b0;
                    state  <= ST_ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debounce_arbiter.sv
// Scoreboard bench for debounce_arbiter: timestamp-based reference model feeds an edge queue.
// Honours DEBOUNCE_ARB_SYNC_EN the same way as the design (two extra input stages).
module tb_debounce_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned T  = 8;
    localparam int unsigned CW = 8;
`ifdef DEBOUNCE_ARB_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    typedef struct {
        int idx;
        bit val;
    } edge_exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] signal_in = '0;
    logic [N-1:0] signal_out;
    logic [N-1:0] edge_out;
    logic         busy;
    logic [1:0]   grant;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    edge_exp_t    exp_q[$];
    logic [N-1:0] m_deb = '0;
    int           m_owner = -1;
    int           m_gcyc = 0;
    bit           m_sample = 1'b0;
    int           m_lastg = N - 1;
    int           m_grant = 0;
    logic [N-1:0] m_s1 = '0;
    logic [N-1:0] m_s2 = '0;

    int edge_cnt[N];
    int edge_cyc[N];

    debounce_arbiter #(
        .N_INPUTS      (N),
        .TIME_DEBOUNCE (T),
        .CNT_WIDTH     (CW)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .signal_i (signal_in),
        .signal_o (signal_out),
        .edge_o   (edge_out),
        .busy_o   (busy),
        .grant_o  (grant)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, actual, required);
        end
    endtask

    // Reference model: a line owns the counter from its grant cycle g; it is aborted
    // if it differs from its sample in cycles g+1..g+T, and commits in cycle g+T+1.
    initial begin
        logic [N-1:0] x;
        logic [N-1:0] req;
        int age;
        int j;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_deb = '0; m_owner = -1; m_lastg = N - 1; m_grant = 0;
                m_s1 = '0; m_s2 = '0; m_sample = 1'b0;
            end else begin
`ifdef DEBOUNCE_ARB_SYNC_EN
                x = m_s2;
                m_s2 = m_s1;
                m_s1 = signal_in;
`else
                x = signal_in;
`endif
                if (m_owner < 0) begin
                    req = x ^ m_deb;
                    for (int k = 1; k <= N; k++) begin
                        j = (m_lastg + k) % N;
                        if (m_owner < 0 && req[j]) begin
                            m_owner = j; m_lastg = j; m_grant = j;
                            m_gcyc = cyc; m_sample = x[j];
                        end
                    end
                end else begin
                    age = cyc - m_gcyc;
                    if (age <= T) begin
                        if (x[m_owner] != m_sample) m_owner = -1;
                    end else begin
                        m_deb[m_owner] = m_sample;
                        exp_q.push_back('{idx: m_owner, val: m_sample});
                        m_owner = -1;
                    end
                end
            end
            cyc++;
        end
    end

    // Monitor: samples DUT outputs mid-cycle and pops the scoreboard on every edge slot.
    initial begin
        edge_exp_t e;
        logic [N-1:0] exp_edge;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                check("reset_outputs", int'({signal_out, edge_out, busy, grant}), 0);
            end else begin
                check("signal_o", int'(signal_out), int'(m_deb));
                check("busy_o", int'(busy), int'(m_owner >= 0));
                check("grant_o", int'(grant), m_grant);
                exp_edge = '0;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    exp_edge[e.idx] = 1'b1;
                    check("edge_level", int'(signal_out[e.idx]), int'(e.val));
                end
                check("edge_o", int'(edge_out), int'(exp_edge));
            end
            for (int i = 0; i < N; i++) begin
                if (edge_out[i]) begin
                    edge_cnt[i]++;
                    edge_cyc[i] = cyc;
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input logic [N-1:0] lvl);
        step(1);
        signal_in = lvl;
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        signal_in = '0;
        step(1);
    endtask

    initial begin
        int s;
        int hold[N];
        int base;
        for (int i = 0; i < N; i++) begin
            edge_cnt[i] = 0;
            edge_cyc[i] = -1;
            hold[i] = 1;
        end

        do_reset(4'b1111);

        s = cyc; signal_in[2] = 1'b1;
        step(T + 6);
        check("single_rise_latency", edge_cyc[2] - s, T + 2 + SYNC_LAT);
        check("single_rise_pulses", edge_cnt[2], 1);
        do_reset('0);

        base = edge_cnt[1];
        signal_in[1] = 1'b1; step(5);
        signal_in[1] = 1'b0; step(T + 8);
        check("bounce_no_edge", edge_cnt[1] - base, 0);
        check("bounce_level", int'(signal_out[1]), 0);
        do_reset('0);

        s = cyc; signal_in[0] = 1'b1; signal_in[3] = 1'b1;
        step(2 * T + 10);
        check("simul_bit0_latency", edge_cyc[0] - s, T + 2 + SYNC_LAT);
        check("simul_bit3_latency", edge_cyc[3] - s, 2 * T + 4 + SYNC_LAT);
        do_reset('0);

        signal_in[1] = 1'b1; step(2);
        signal_in[2] = 1'b1; step(1);
        signal_in[1] = 1'b0; step(1);
        signal_in[1] = 1'b1;
        step(2 * T + 12);
        check("fair_bit2_first", int'(edge_cyc[2] < edge_cyc[1]), 1);
        do_reset('0);

        base = edge_cnt[0];
        signal_in[0] = 1'b1; step(5 + SYNC_LAT);
        do_reset('0);
        step(T + 6);
        check("midcount_reset_no_commit", edge_cnt[0] - base, 0);

        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                hold[i]--;
                if (hold[i] <= 0) begin
                    signal_in[i] = ~signal_in[i];
                    hold[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4))
                                                         : int'($urandom_range(T, 4 * T));
                end
            end
            if ($urandom_range(0, 799) == 0) begin
                rst = 1'b1; step(2); rst = 1'b0;
            end else begin
                step(1);
            end
        end
        signal_in = '0;
        step(N * (T + 3) + 10);
        check("final_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
